// File: rtl/tx_framer_if.sv
// Byte-input handshake for tx_framer: a byte moves on a cycle where din_valid && din_ready.
// din_ready is driven from registered state only, never from din_valid/din_last/din.
interface tx_framer_if;
    logic [7:0] din;
    logic       din_valid;
    logic       din_last;
    logic       din_ready;

    modport master (output din, output din_valid, output din_last, input din_ready);
    modport slave  (input din, input din_valid, input din_last, output din_ready);
endinterface

// File: rtl/tx_framer.sv
// HDLC-style Econet transmit framer: flags, zero-stuffed LSB-first data, CRC-CCITT FCS, abort.
// Optional build macro TX_IDLE_FLAGS_EN makes the idle line carry back-to-back flags instead of 1s.
module tx_framer #(
    parameter int OPEN_FLAGS  = 1,
    parameter int CLOSE_FLAGS = 1
) (
    input  logic        netclk,
    input  logic        reset,
    tx_framer_if.slave  bus,
    input  logic        start,
    input  logic        abort,
    output logic        txdata,
    output logic        tx_active,
    output logic        frame_done,
    output logic        frame_aborted,
    output logic        underrun,
    output logic [2:0]  o_dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE, S_OPEN_FLAG, S_DATA, S_FCS, S_CLOSE_FLAG, S_ABORT
    } state_t;

    localparam logic [7:0] FLAG       = 8'h7E;
    localparam logic [3:0] OPEN_LAST  = 4'(OPEN_FLAGS - 1);
    localparam logic [3:0] CLOSE_LAST = 4'(CLOSE_FLAGS - 1);
`ifdef TX_IDLE_FLAGS_EN
    localparam logic IDLE_BIT0 = 1'b0;
`else
    localparam logic IDLE_BIT0 = 1'b1;
`endif

    state_t      r_state;
    logic [2:0]  r_bitcnt;
    logic [3:0]  r_flagcnt;
    logic [3:0]  r_fcscnt;
    logic [2:0]  r_ones;
    logic [7:0]  r_shift;
    logic        r_cur_last;
    logic [7:0]  r_hold;
    logic        r_hold_full;
    logic        r_hold_last;
    logic        r_last_acc;
    logic [15:0] r_lfsr;
    logic        r_txdata;
    logic        r_frame_done;
    logic        r_frame_aborted;
    logic        r_underrun;
`ifdef TX_IDLE_FLAGS_EN
    logic        r_start_pend;
`endif

    logic [2:0]  w_bit_next;
    logic [3:0]  w_fcs_next;
    logic        w_data_bit;
    logic        w_fcs_bit;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], fb} ^ (fb ? 16'h1020 : 16'h0000);
    endfunction

    // State and counters always describe the bit currently on txdata.
    assign w_bit_next = r_bitcnt + 3'd1;
    assign w_fcs_next = r_fcscnt + 4'd1;
    assign w_data_bit = r_shift[w_bit_next];
    assign w_fcs_bit  = ~r_lfsr[~w_fcs_next];

    assign bus.din_ready  = !r_hold_full && !r_last_acc &&
                            (r_state == S_OPEN_FLAG || r_state == S_DATA);
    assign txdata         = r_txdata;
    assign tx_active      = (r_state != S_IDLE);
    assign frame_done     = r_frame_done;
    assign frame_aborted  = r_frame_aborted;
    assign underrun       = r_underrun;
    assign o_dbg_state    = r_state;

    always_ff @(posedge netclk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_bitcnt        <= 3'd7;
            r_flagcnt       <= 4'd0;
            r_fcscnt        <= 4'd0;
            r_ones          <= 3'd0;
            r_shift         <= 8'd0;
            r_cur_last      <= 1'b0;
            r_hold          <= 8'd0;
            r_hold_full     <= 1'b0;
            r_hold_last     <= 1'b0;
            r_last_acc      <= 1'b0;
            r_lfsr          <= 16'hFFFF;
            r_txdata        <= 1'b1;
            r_frame_done    <= 1'b0;
            r_frame_aborted <= 1'b0;
            r_underrun      <= 1'b0;
`ifdef TX_IDLE_FLAGS_EN
            r_start_pend    <= 1'b0;
`endif
        end else begin
            r_frame_done    <= 1'b0;
            r_frame_aborted <= 1'b0;
            r_underrun      <= 1'b0;

            if (bus.din_valid && bus.din_ready) begin
                r_hold      <= bus.din;
                r_hold_full <= 1'b1;
                r_hold_last <= bus.din_last;
                r_last_acc  <= r_last_acc | bus.din_last;
            end

            case (r_state)
                S_IDLE: begin
`ifdef TX_IDLE_FLAGS_EN
                    r_bitcnt <= w_bit_next;
                    r_txdata <= FLAG[w_bit_next];
                    if (r_bitcnt == 3'd7 && (start || r_start_pend)) begin
                        r_start_pend <= 1'b0;
                        r_state      <= S_OPEN_FLAG;
                        r_flagcnt    <= 4'd0;
                        r_lfsr       <= 16'hFFFF;
                        r_ones       <= 3'd0;
                        r_last_acc   <= 1'b0;
                    end else if (start) begin
                        r_start_pend <= 1'b1;
                    end
`else
                    r_txdata <= 1'b1;
                    if (start) begin
                        r_state    <= S_OPEN_FLAG;
                        r_bitcnt   <= 3'd0;
                        r_flagcnt  <= 4'd0;
                        r_txdata   <= FLAG[0];
                        r_lfsr     <= 16'hFFFF;
                        r_ones     <= 3'd0;
                        r_last_acc <= 1'b0;
                    end
`endif
                end
                S_OPEN_FLAG, S_DATA: begin
                    if (r_state == S_DATA && r_ones == 3'd5) begin
                        r_txdata <= 1'b0;
                        r_ones   <= 3'd0;
                    end else if (r_bitcnt != 3'd7) begin
                        r_bitcnt <= w_bit_next;
                        if (r_state == S_OPEN_FLAG) begin
                            r_txdata <= FLAG[w_bit_next];
                        end else begin
                            r_txdata <= w_data_bit;
                            r_ones   <= w_data_bit ? r_ones + 3'd1 : 3'd0;
                            r_lfsr   <= crc_step(r_lfsr, w_data_bit);
                        end
                    end else if (r_state == S_OPEN_FLAG && r_flagcnt != OPEN_LAST) begin
                        r_flagcnt <= r_flagcnt + 4'd1;
                        r_bitcnt  <= 3'd0;
                        r_txdata  <= FLAG[0];
                    end else if (r_state == S_DATA && r_cur_last) begin
                        r_state  <= S_FCS;
                        r_fcscnt <= 4'd0;
                        r_txdata <= ~r_lfsr[15];
                        r_ones   <= ~r_lfsr[15] ? r_ones + 3'd1 : 3'd0;
                    end else if (r_hold_full) begin
                        // Byte boundary: the holding register frees as the shifter loads.
                        r_state     <= S_DATA;
                        r_shift     <= r_hold;
                        r_cur_last  <= r_hold_last;
                        r_hold_full <= 1'b0;
                        r_bitcnt    <= 3'd0;
                        r_txdata    <= r_hold[0];
                        r_ones      <= r_hold[0] ? r_ones + 3'd1 : 3'd0;
                        r_lfsr      <= crc_step(r_lfsr, r_hold[0]);
                    end else begin
                        r_state    <= S_ABORT;
                        r_bitcnt   <= 3'd0;
                        r_txdata   <= 1'b1;
                        r_ones     <= 3'd0;
                        r_underrun <= 1'b1;
                    end
                end
                S_FCS: begin
                    if (r_ones == 3'd5) begin
                        r_txdata <= 1'b0;
                        r_ones   <= 3'd0;
                    end else if (r_fcscnt != 4'd15) begin
                        r_fcscnt <= w_fcs_next;
                        r_txdata <= w_fcs_bit;
                        r_ones   <= w_fcs_bit ? r_ones + 3'd1 : 3'd0;
                    end else begin
                        r_state   <= S_CLOSE_FLAG;
                        r_bitcnt  <= 3'd0;
                        r_flagcnt <= 4'd0;
                        r_txdata  <= FLAG[0];
                        r_ones    <= 3'd0;
                    end
                end
                S_CLOSE_FLAG: begin
                    if (r_bitcnt != 3'd7) begin
                        r_bitcnt <= w_bit_next;
                        r_txdata <= FLAG[w_bit_next];
                    end else if (r_flagcnt != CLOSE_LAST) begin
                        r_flagcnt <= r_flagcnt + 4'd1;
                        r_bitcnt  <= 3'd0;
                        r_txdata  <= FLAG[0];
                    end else begin
                        r_state      <= S_IDLE;
                        r_bitcnt     <= 3'd0;
                        r_txdata     <= IDLE_BIT0;
                        r_frame_done <= 1'b1;
                    end
                end
                S_ABORT: begin
                    if (r_bitcnt != 3'd7) begin
                        r_bitcnt <= w_bit_next;
                        r_txdata <= 1'b1;
                    end else begin
                        r_state         <= S_IDLE;
                        r_bitcnt        <= 3'd0;
                        r_txdata        <= IDLE_BIT0;
                        r_frame_aborted <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // A requested abort overrides whatever the state machine chose this cycle.
            if (abort && r_state != S_IDLE && r_state != S_ABORT) begin
                r_state      <= S_ABORT;
                r_bitcnt     <= 3'd0;
                r_txdata     <= 1'b1;
                r_ones       <= 3'd0;
                r_hold_full  <= 1'b0;
                r_underrun   <= 1'b0;
                r_frame_done <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tx_framer.sv
// Directed bench for tx_framer: captures the serial line while tx_active and checks it against
// hand-computed bit patterns and a destuffing/CRC receive model.
module tb_tx_framer;
    logic       netclk = 1'b0;
    logic       reset  = 1'b1;
    logic       start  = 1'b0;
    logic       abort  = 1'b0;
    logic       txdata, tx_active, frame_done, frame_aborted, underrun;
    logic [2:0] dbg_state;

    tx_framer_if bus();

    tx_framer #(.OPEN_FLAGS(1), .CLOSE_FLAGS(1)) dut (
        .netclk        (netclk),
        .reset         (reset),
        .bus           (bus),
        .start         (start),
        .abort         (abort),
        .txdata        (txdata),
        .tx_active     (tx_active),
        .frame_done    (frame_done),
        .frame_aborted (frame_aborted),
        .underrun      (underrun),
        .o_dbg_state   (dbg_state)
    );

    always #5 netclk = ~netclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line capture and pulse bookkeeping.
    logic       cap_q[$];
    logic       rdy_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] tx_bytes[$];
    int done_cnt, abt_cnt, und_cnt, und_idx, abt_idx, feed_to;

    always @(negedge netclk) begin
        if (!reset) begin
            if (underrun) begin
                und_cnt++;
                und_idx = cap_q.size();
            end
            if (frame_done) done_cnt++;
            if (frame_aborted) begin
                abt_cnt++;
                abt_idx = cap_q.size();
            end
            if (tx_active) begin
                cap_q.push_back(txdata);
                rdy_q.push_back(bus.din_ready);
            end
        end
    end

    task automatic clear_cap();
        cap_q.delete();
        rdy_q.delete();
        exp_q.delete();
        done_cnt = 0; abt_cnt = 0; und_cnt = 0;
        und_idx = -1; abt_idx = -1; feed_to = 0;
    endtask

    function automatic logic [63:0] pack(input int from, input int n);
        logic [63:0] v;
        v = '0;
        for (int i = from; i < from + n; i++)
            v = {v[62:0], (i >= 0 && i < cap_q.size()) ? cap_q[i] : 1'bx};
        return v;
    endfunction

    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic b);
        logic [15:0] n;
        n = c << 1;
        if (c[15] ^ b) n = n ^ 16'h1021;
        return n;
    endfunction

    task automatic start_frame();
        @(negedge netclk);
        start = 1'b1;
        @(negedge netclk);
        start = 1'b0;
    endtask

    task automatic feed(input int n, input bit with_last);
        int waited;
        for (int i = 0; i < n; i++) begin
            bus.din       = tx_bytes[i];
            bus.din_valid = 1'b1;
            bus.din_last  = with_last && (i == n - 1);
            waited = 0;
            while (!bus.din_ready && waited < 300) begin
                @(negedge netclk);
                waited++;
            end
            if (waited >= 300) begin
                feed_to++;
                break;
            end
            @(negedge netclk);
        end
        bus.din_valid = 1'b0;
        bus.din_last  = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int cyc;
        cyc = 0;
        while (done_cnt + abt_cnt == 0 && cyc < 5000) begin
            @(posedge netclk);
            cyc++;
        end
        check({tag, "_ended"}, (done_cnt + abt_cnt != 0), 1);
        repeat (2) @(posedge netclk);
        check({tag, "_idle_txdata"}, txdata, 1'b1);
        check({tag, "_idle_active"}, tx_active, 1'b0);
        @(negedge netclk);
    endtask

    // Receive model: strips one flag each end, destuffs, rebuilds bytes, runs the CRC to its residue.
    task automatic deframe(input string tag, input int nexp);
        logic        bits[$];
        logic        b;
        logic [15:0] crc;
        logic [7:0]  byte_v;
        int ones, run, max_run, stuff_err, byte_err, nb;
        ones = 0; run = 0; max_run = 0; stuff_err = 0; byte_err = 0; crc = 16'hFFFF;
        for (int i = 8; i < cap_q.size() - 8; i++) begin
            b = cap_q[i];
            run = b ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (ones == 5) begin
                if (b) stuff_err++;
                ones = 0;
            end else begin
                bits.push_back(b);
                ones = b ? ones + 1 : 0;
                crc = crc_model(crc, b);
            end
        end
        if (bits.size() < 16 || bits.size() % 8 != 0) stuff_err++;
        nb = (bits.size() >= 16) ? (bits.size() - 16) / 8 : 0;
        for (int k = 0; k < nb; k++) begin
            byte_v = '0;
            for (int j = 0; j < 8; j++) byte_v[j] = bits[k * 8 + j];
            if (exp_q.size() == 0) byte_err++;
            else if (exp_q.pop_front() !== byte_v) byte_err++;
        end
        byte_err += exp_q.size();
        exp_q.delete();
        check({tag, "_nbytes"}, nb, nexp);
        check({tag, "_byte_errs"}, byte_err, 0);
        check({tag, "_stuff_errs"}, stuff_err, 0);
        check({tag, "_residue"}, crc, 16'h1D0F);
        check({tag, "_max_ones_le5"}, (max_run <= 5), 1);
        check({tag, "_open_flag"}, pack(0, 8), 8'h7E);
        check({tag, "_close_flag"}, pack(cap_q.size() - 8, 8), 8'h7E);
    endtask

    task automatic run_single_zero(input string tag);
        clear_cap();
        tx_bytes = '{8'h00};
        fork
            feed(1, 1'b1);
            start_frame();
        join
        wait_end(tag);
        check({tag, "_len"}, cap_q.size(), 40);
        check({tag, "_bits"}, pack(0, 40), 40'b01111110_00000000_0001111000001111_01111110);
        check({tag, "_done"}, done_cnt, 1);
        check({tag, "_aborted"}, abt_cnt, 0);
        check({tag, "_underrun"}, und_cnt, 0);
        check({tag, "_feed_timeouts"}, feed_to, 0);
    endtask

    int r_sum;
    logic rdy_a, rdy_b;

    initial begin
        bus.din = 8'h00;
        bus.din_valid = 1'b0;
        bus.din_last = 1'b0;
        clear_cap();
        repeat (3) @(negedge netclk);
        check("rst_txdata", txdata, 1'b1);
        check("rst_active", tx_active, 1'b0);
        check("rst_ready", bus.din_ready, 1'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_aborted", frame_aborted, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge netclk);

        // abort in IDLE has no effect
        abort = 1'b1;
        @(negedge netclk);
        abort = 1'b0;
        check("idle_abort_active", tx_active, 1'b0);
        check("idle_abort_txdata", txdata, 1'b1);

        run_single_zero("v1");

        // 0xFF then 0x00: stuffed zero after five ones of data
        clear_cap();
        tx_bytes = '{8'hFF, 8'h00};
        exp_q = '{8'hFF, 8'h00};
        fork
            feed(2, 1'b1);
            start_frame();
        join
        wait_end("v2");
        check("v2_head_bits", pack(0, 25), 25'b01111110_111110111_00000000);
        check("v2_done", done_cnt, 1);
        deframe("v2", 2);

        // Underrun at the end of byte 1
        clear_cap();
        tx_bytes = '{8'hA5};
        fork
            feed(1, 1'b0);
            start_frame();
        join
        repeat (9) @(negedge netclk);
        rdy_a = bus.din_ready;
        bus.din_valid = 1'b1;
        #1;
        rdy_b = bus.din_ready;
        bus.din_valid = 1'b0;
        check("und_ready_mid_byte", rdy_a, 1'b1);
        check("und_ready_with_valid", rdy_b, 1'b1);
        wait_end("und");
        check("und_len", cap_q.size(), 24);
        check("und_bits", pack(0, 24), 24'b01111110_10100101_11111111);
        check("und_pulses", und_cnt, 1);
        check("und_pulse_pos", und_idx, 16);
        check("und_aborted", abt_cnt, 1);
        check("und_aborted_pos", abt_idx, 24);
        check("und_done", done_cnt, 0);
        r_sum = 0;
        for (int i = 16; i < 24 && i < rdy_q.size(); i++) r_sum += int'(rdy_q[i]);
        check("und_ready_in_abort", r_sum, 0);

        // abort during bit 3 of byte 2
        clear_cap();
        tx_bytes = '{8'h12, 8'h34, 8'h56};
        fork
            feed(3, 1'b1);
            begin
                start_frame();
                repeat (19) @(negedge netclk);
                abort = 1'b1;
                @(negedge netclk);
                abort = 1'b0;
            end
        join
        wait_end("abt");
        check("abt_len", cap_q.size(), 28);
        check("abt_bits", pack(0, 28), 28'b01111110_01001000_0010_11111111);
        check("abt_aborted", abt_cnt, 1);
        check("abt_aborted_pos", abt_idx, 28);
        check("abt_done", done_cnt, 0);
        check("abt_underrun", und_cnt, 0);
        check("abt_ready_after", bus.din_ready, 1'b0);

        // 256 back-to-back bytes
        clear_cap();
        tx_bytes.delete();
        for (int i = 0; i < 256; i++) begin
            tx_bytes.push_back(8'(i));
            exp_q.push_back(8'(i));
        end
        fork
            feed(256, 1'b1);
            start_frame();
        join
        wait_end("big");
        check("big_underrun", und_cnt, 0);
        check("big_done", done_cnt, 1);
        check("big_feed_timeouts", feed_to, 0);
        deframe("big", 256);

        // Reset in the middle of the FCS, then a fresh frame
        clear_cap();
        tx_bytes = '{8'h00};
        fork
            feed(1, 1'b1);
            start_frame();
        join
        repeat (19) @(negedge netclk);
        check("mid_fcs_active_before", tx_active, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_mid_txdata", txdata, 1'b1);
        check("rst_mid_active", tx_active, 1'b0);
        check("rst_mid_ready", bus.din_ready, 1'b0);
        @(negedge netclk);
        reset = 1'b0;
        @(negedge netclk);
        run_single_zero("v1b");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/tx_framer.md
Name: tx_framer

Overview:
HDLC-style serial transmit framer for the Econet link. It is the transmit-side counterpart of the bit-serial receive deframer.
- Takes bytes over a valid/ready interface and sends one bit per netclk cycle, LSB first.
- Each frame is: opening flag(s), zero-bit-stuffed data, 16-bit CRC-CCITT FCS, closing flag(s).
- Between frames the line idles at all-ones. Frames can be aborted by request or on underrun.

Parameters:
OPEN_FLAGS, 1, number of 01111110 flags sent before the first data bit (1..15)
CLOSE_FLAGS, 1, number of flags sent after the FCS (1..15)

Ports:
netclk  in  1  bit clock; all logic on posedge
reset  in  1  asynchronous, active-high reset
start  in  1  frame request; sampled only in IDLE
abort  in  1  abort request; honoured in any non-IDLE state
din  in  8  data byte
din_valid  in  1  din holds a byte
din_last  in  1  qualifies din as the final byte of the frame
din_ready  out  1  holding register empty, byte accepted when din_valid&&din_ready
txdata  out  1  registered serial line output
tx_active  out  1  high while flag/data/FCS/abort bits are on txdata
frame_done  out  1  one-cycle pulse after the last closing-flag bit
frame_aborted  out  1  one-cycle pulse after the last abort bit
underrun  out  1  one-cycle pulse when the shifter needed a byte and the holding register was empty

Behaviour:
- Reset state: IDLE. txdata=1, din_ready=0, tx_active=0, all pulses 0, holding register empty, LFSR=16'hFFFF.
- States: IDLE, OPEN_FLAG, DATA, FCS, CLOSE_FLAG, ABORT.
- IDLE: txdata=1. When start=1, the first flag bit appears on txdata in the next cycle; LFSR is loaded with 16'hFFFF.
- Flags: 01111110 sent LSB first (bit order 0,1,1,1,1,1,1,0). Flags are never stuffed, and each flag clears the ones counter.
- OPEN_FLAG: sends OPEN_FLAGS flags back to back.
  - During the last flag bit, the holding register must be full; if empty, go to ABORT and pulse underrun.
  - Otherwise the byte moves to the shifter, and its bit0 is on txdata in the cycle after the final flag bit.
- din_ready = 1 when the holding register is empty and the state is OPEN_FLAG or DATA, and a din_last byte has not yet been accepted in this frame. It is 0 in every other state.
- Handshake:
  - A byte is accepted on a cycle where din_valid && din_ready.
  - The holding register frees in the same cycle its byte moves to the shifter.
  - din_ready rises in the following cycle; no combinational path from the din_* inputs to din_ready.
- DATA:
  - Sends shifter bits LSB first.
  - Each data bit updates the LFSR: fb = bit ^ lfsr[15]; lfsr <= {lfsr[14:0],fb} ^ (fb ? 16'h1020 : 0), i.e. taps at bits 5 and 12, polynomial x^16+x^12+x^5+1.
  - Stuff bits do not update the LFSR.
- Bit stuffing:
  - After five consecutive 1s of data or FCS, a single 0 is inserted and the shifter holds for that cycle.
  - The stuffed 0 resets the ones counter.
  - A stuff bit may follow bit7; the next byte then starts after it.
- End of byte (cycle after bit7, or after its trailing stuff bit):
  - If the last byte had din_last, go to FCS.
  - Otherwise load from the holding register.
  - If the holding register is empty, go to ABORT and pulse underrun.
- FCS:
  - LFSR is frozen; 16 bits sent in the order ~lfsr[15], ~lfsr[14] … ~lfsr[0].
  - Stuffing is applied as for data.
  - Then go to CLOSE_FLAG.
- CLOSE_FLAG: sends CLOSE_FLAGS flags. frame_done pulses in the cycle after the last flag bit, then IDLE with txdata=1.
- ABORT:
  - Sends eight consecutive 1s, unstuffed, starting the cycle after entry; entry can be mid-byte or mid-flag.
  - frame_aborted pulses after the eighth 1, then IDLE.
  - The holding register is cleared on entry.
  - abort=1 while already in ABORT is ignored.
- Simultaneous events:
  - abort has priority over every state transition, including underrun; underrun is not pulsed if abort=1 in the same cycle.
  - start is ignored outside IDLE.
- tx_active is high for every non-IDLE cycle and low in IDLE.
- Reset asserted mid-frame returns to the reset state immediately. No abort sequence is sent; the line goes to 1.

Optional Feature:
TX_IDLE_FLAGS_EN
- Defined:
  - IDLE continuously sends flags instead of 1s, and tx_active stays 0.
  - A start request waits for the current idle flag to finish (bit 7) before OPEN_FLAG begins.
  - ABORT still sends eight 1s, then resumes idle flags.
- Undefined: IDLE sends constant 1, as described above.

Test Plan:
- Single byte 0x00, din_last=1, OPEN_FLAGS=CLOSE_FLAGS=1 -> txdata after start: 0,1,1,1,1,1,1,0, then 0×8, then FCS 0,0,0,1,1,1,1,0,0,0,0,0,1,1,1,1 (~0xE1F0=0x1E0F, MSB first), then 0,1,1,1,1,1,1,0, then frame_done pulse, txdata=1.
- Byte 0xFF then 0x00 (last) -> data bits 1,1,1,1,1,0(stuff),1,1,1,0×8; no more than five consecutive 1s anywhere between the flags; LFSR result identical to the unstuffed computation.
- Holding register empty at the end of byte 1 of a 3-byte frame -> underrun pulse, eight 1s on txdata, frame_aborted pulse, IDLE; din_ready=0 throughout ABORT.
- abort asserted at data bit 3 of byte 2 -> the next cycle starts eight 1s; frame_aborted after 8 cycles; no closing flag sent.
- Back-to-back din_valid with 256-byte frame -> no underrun; din_ready never depends combinationally on din_valid; a deframer model receives all 256 bytes with FCS residue 0x1D0F.
- Reset asserted mid-FCS -> txdata=1, tx_active=0, din_ready=0 immediately; start issued after reset yields a correct fresh frame.
